// File: rtl/store_align_buffer_if.sv
// rtl/store_align_buffer_if.sv - CPU store/load request and RAM write-port bundle.
interface store_align_buffer_if #(
  parameter int ADDR_W = 10
);
  logic              cpu_we;
  logic              cpu_re;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [1:0]        cpu_width;
  logic              cpu_stall;
  logic              misalign_err;
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_wea;
  logic [31:0]       ram_dina;
  logic [31:0]       stall_cnt;

  modport master (
    output cpu_we, cpu_re, cpu_addr, cpu_wdata, cpu_width,
    input  cpu_stall, misalign_err, ram_addr, ram_wea, ram_dina, stall_cnt
  );

  modport slave (
    input  cpu_we, cpu_re, cpu_addr, cpu_wdata, cpu_width,
    output cpu_stall, misalign_err, ram_addr, ram_wea, ram_dina, stall_cnt
  );
endinterface

// File: rtl/store_align_buffer.sv
// rtl/store_align_buffer.sv - lane-steering store FIFO draining into a byte-enable RAM port.
// Optional stall-cycle counter enabled by STBUF_STALL_CNT_EN.
module store_align_buffer #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 10
) (
  input logic                clk,
  input logic                rst,
  store_align_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [3:0]        wea;
    logic [31:0]       data;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   last_dina;
  logic          misalign_q;

  logic [1:0]    off;
  logic          st_valid;
  logic [3:0]    st_wea;
  logic [31:0]   st_data;
  logic          empty;
  logic          pop;
  logic          push;
  logic          stall;
  logic          unused;

  assign off    = bus.cpu_addr[1:0];
  assign unused = ^{bus.cpu_addr[31:ADDR_W+2]};

  always_comb begin
    st_valid = 1'b0;
    st_wea   = 4'b0000;
    st_data  = bus.cpu_wdata << {off, 3'b000};
    case (bus.cpu_width)
      2'b00: begin
        st_valid = 1'b1;
        st_wea   = 4'b0001 << off;
      end
      2'b01: begin
        if (off != 2'd3) begin
          st_valid = 1'b1;
          st_wea   = 4'b0011 << off;
        end
      end
      2'b10: begin
        if (off == 2'd0) begin
          st_valid = 1'b1;
          st_wea   = 4'b1111;
        end
      end
      default: ;
    endcase
  end

  assign empty = (count == '0);
  assign pop   = !empty;
  assign head  = mem[rd_ptr];

  // Loads stall on any pending write: the single RAM port is busy showing the head.
  assign stall = (bus.cpu_we && (count == CW'(DEPTH)) && !pop) || (bus.cpu_re && !empty);
  assign push  = bus.cpu_we && st_valid && !stall;

  assign bus.cpu_stall    = stall;
  assign bus.misalign_err = misalign_q;
  assign bus.ram_addr     = empty ? bus.cpu_addr[ADDR_W+1:2] : head.addr;
  assign bus.ram_wea      = empty ? 4'b0000 : head.wea;
  assign bus.ram_dina     = empty ? last_dina : head.data;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{addr: bus.cpu_addr[ADDR_W+1:2], wea: st_wea, data: st_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_dina  <= '0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= bus.cpu_we && !st_valid;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + PW'(1);
        last_dina <= head.data;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

`ifdef STBUF_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`else
  assign bus.stall_cnt = 32'h0;
`endif
endmodule

// File: tb/tb_store_align_buffer.sv
// tb/tb_store_align_buffer.sv - scoreboard bench for store_align_buffer.
module tb_store_align_buffer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  store_align_buffer_if #(.ADDR_W(10)) bus ();

  store_align_buffer #(.DEPTH(2), .ADDR_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [9:0]  addr;
    logic [3:0]  wea;
    logic [31:0] data;
  } wr_t;

  wr_t         sb[$];
  int          checks = 0;
  int          errors = 0;
  int          pending = 0;
  bit          exp_mis = 1'b0;
  bit          last_stall = 1'b0;
  logic [31:0] exp_cnt = '0;
  logic [31:0] last_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Store legality from byte count: the access must fit inside one aligned word.
  function automatic bit model_store(input logic [31:0] addr, input logic [31:0] wdata,
                                     input logic [1:0] width, output wr_t w);
    int bytes;
    int o;
    bytes  = 1 << width;
    o      = int'(addr[1:0]);
    w.addr = addr[11:2];
    w.wea  = 4'(((1 << bytes) - 1) << o);
    w.data = wdata << (8 * o);
    return (o + bytes) <= 4;
  endfunction

  task automatic step(input bit we, input bit re, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [1:0] width);
    wr_t w;
    bit  ok;
    bit  stall_exp;
    @(posedge clk);
    #1;
    bus.cpu_we    = we;
    bus.cpu_re    = re;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    bus.cpu_width = width;
    @(negedge clk);
    stall_exp = re && (pending > 0);
    chk("cpu_stall", bus.cpu_stall, stall_exp);
    chk("misalign_err", bus.misalign_err, exp_mis);
`ifdef STBUF_STALL_CNT_EN
    chk("stall_cnt", bus.stall_cnt, exp_cnt);
`else
    chk("stall_cnt", bus.stall_cnt, 0);
`endif
    if (pending == 0) chk("ram_addr_idle", bus.ram_addr, addr[11:2]);
    ok      = model_store(addr, wdata, width, w);
    exp_mis = we && !ok;
    if (pending > 0) pending--;
    if (we && ok && !stall_exp) begin
      sb.push_back(w);
      pending++;
    end
    if (stall_exp) exp_cnt++;
    last_stall = stall_exp;
  endtask

  // Monitor samples well after the edge, before the driver pushes the next expectation.
  always @(posedge clk) begin
    #2;
    if (rst) begin
      last_data = '0;
    end else if (bus.ram_wea != 4'b0000) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", {bus.ram_addr, bus.ram_wea}, 0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", bus.ram_addr, e.addr);
        chk("wr_wea", bus.ram_wea, e.wea);
        chk("wr_data", bus.ram_dina, e.data);
        last_data = e.data;
      end
    end else begin
      chk("ram_dina_hold", bus.ram_dina, last_data);
    end
  end

  initial begin
    logic [1:0]  wd;
    logic [31:0] ad;
    logic [31:0] dt;
    bit          we_r;
    bit          re_r;
    rst           = 1'b1;
    bus.cpu_we    = 1'b0;
    bus.cpu_re    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.cpu_width = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_wea", bus.ram_wea, 0);
    chk("reset_dina", bus.ram_dina, 0);
    chk("reset_misalign", bus.misalign_err, 0);
    chk("reset_stall_cnt", bus.stall_cnt, 0);
    chk("reset_stall", bus.cpu_stall, 0);

    step(1, 0, 32'h103, 32'hAB, 2'b00);
    step(0, 0, 32'h0, 32'h0, 2'b00);
    chk("byte_addr", bus.ram_addr, 10'h040);
    chk("byte_wea", bus.ram_wea, 4'b1000);
    chk("byte_dina", bus.ram_dina, 32'hAB000000);
    step(0, 0, 32'h0, 32'h0, 2'b00);
    chk("byte_drained", bus.ram_wea, 0);

    step(1, 0, 32'h002, 32'h1234, 2'b01);
    step(1, 0, 32'h003, 32'h5678, 2'b01);
    chk("half_wea", bus.ram_wea, 4'b1100);
    chk("half_dina", bus.ram_dina, 32'h12340000);
    step(0, 0, 32'h0, 32'h0, 2'b00);
    chk("misalign_pulse", bus.misalign_err, 1);
    chk("misalign_no_write", bus.ram_wea, 0);
    step(0, 0, 32'h0, 32'h0, 2'b00);
    chk("misalign_one_cycle", bus.misalign_err, 0);

    step(1, 0, 32'h10, 32'h11111111, 2'b10);
    step(1, 0, 32'h14, 32'h22222222, 2'b10);
    step(1, 0, 32'h18, 32'h33333333, 2'b10);
    chk("full_pop_no_stall", bus.cpu_stall, 0);
    chk("full_pop_head", bus.ram_addr, 10'h005);
    step(0, 0, 32'h0, 32'h0, 2'b00);
    step(0, 0, 32'h0, 32'h0, 2'b00);

    step(1, 0, 32'h20, 32'hCAFEF00D, 2'b10);
    step(0, 1, 32'h20, 32'h0, 2'b00);
    chk("hazard_stall", bus.cpu_stall, 1);
    step(0, 1, 32'h20, 32'h0, 2'b00);
    chk("hazard_release", bus.cpu_stall, 0);
    chk("hazard_addr", bus.ram_addr, 10'h008);
    step(0, 0, 32'h0, 32'h0, 2'b00);
`ifdef STBUF_STALL_CNT_EN
    chk("hazard_stall_cnt", bus.stall_cnt, 1);
`else
    chk("hazard_stall_cnt", bus.stall_cnt, 0);
`endif

    step(1, 0, 32'h40, 32'h5A5A5A5A, 2'b10);
    @(posedge clk);
    #1;
    bus.cpu_we = 1'b0;
    rst        = 1'b1;
    #1;
    chk("rst_wea_immediate", bus.ram_wea, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    pending = 0;
    exp_mis = 1'b0;
    exp_cnt = '0;
    step(0, 0, 32'h44, 32'h0, 2'b00);
    chk("rst_fifo_empty", bus.ram_wea, 0);
    chk("rst_dina_cleared", bus.ram_dina, 0);

    we_r = 0; re_r = 0; ad = '0; dt = '0; wd = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!last_stall) begin
        int r;
        r    = $urandom_range(0, 9);
        we_r = (r < 5);
        re_r = (r >= 5 && r < 8);
        ad   = $urandom_range(0, 63);
        dt   = $urandom;
        wd   = 2'($urandom_range(0, 3));
      end
      step(we_r, re_r, ad, dt, wd);
    end
    repeat (3) step(0, 0, 32'h0, 32'h0, 2'b00);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
